// File: rtl/pixel_array_pkg.sv
// Shared types and helpers for the pixel array readout sequencer.
// gray2bin is used when PIXEL_ARRAY_GRAY_DECODE_EN is defined.
package pixel_array_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam int unsigned GRAY_MAX_W = 64;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Callers zero-extend a BIT_DEPTH pixel and truncate the result back to BIT_DEPTH.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_array_readout_sequencer_if.sv
// Output beat stream of the readout sequencer: valid/ready with keep mask and frame markers.
interface pixel_array_readout_sequencer_if #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned BIT_DEPTH = 8
);
    logic                       OUT_VALID;
    logic                       OUT_READY;
    logic [LANES*BIT_DEPTH-1:0] OUT_DATA;
    logic [LANES-1:0]           OUT_KEEP;
    logic                       OUT_SOF;
    logic                       OUT_EOL;
    logic                       OUT_EOF;

    modport master (
        output OUT_VALID, OUT_DATA, OUT_KEEP, OUT_SOF, OUT_EOL, OUT_EOF,
        input  OUT_READY
    );

    modport slave (
        input  OUT_VALID, OUT_DATA, OUT_KEEP, OUT_SOF, OUT_EOL, OUT_EOF,
        output OUT_READY
    );
endinterface

// File: rtl/pixel_array_beat_mux.sv
// Row buffer plus beat-to-lane selection with keep mask; registered lane outputs.
// PIXEL_ARRAY_GRAY_DECODE_EN: Gray-to-binary decode of each pixel at row latch.
module pixel_array_beat_mux
    import pixel_array_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned LANES     = 2,
    parameter int unsigned BEAT_W    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture_en,
    input  logic                       load_en,
    input  logic [BEAT_W-1:0]          beat_idx,
    input  logic [WIDTH*BIT_DEPTH-1:0] row_data,
    output logic [LANES*BIT_DEPTH-1:0] lane_data_q,
    output logic [LANES-1:0]           lane_keep_q
);

    localparam int unsigned ROW_BITS = WIDTH * BIT_DEPTH;

    logic [ROW_BITS-1:0]          row_latch;
    logic [ROW_BITS-1:0]          row_buf_q, row_buf_d;
    logic [LANES*BIT_DEPTH-1:0]   lane_data_d;
    logic [LANES-1:0]             lane_keep_d;

    always_comb begin
        row_latch = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
`ifdef PIXEL_ARRAY_GRAY_DECODE_EN
            row_latch[i*BIT_DEPTH +: BIT_DEPTH] =
                BIT_DEPTH'(gray2bin(GRAY_MAX_W'(row_data[i*BIT_DEPTH +: BIT_DEPTH])));
`else
            row_latch[i*BIT_DEPTH +: BIT_DEPTH] = row_data[i*BIT_DEPTH +: BIT_DEPTH];
`endif
        end
    end

    // The capture edge also loads beat 0, so select from the buffer's next value.
    always_comb begin
        row_buf_d   = capture_en ? row_latch : row_buf_q;
        lane_data_d = lane_data_q;
        lane_keep_d = lane_keep_q;
        if (load_en) begin
            lane_data_d = '0;
            lane_keep_d = '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                if (32'(beat_idx) * LANES + l < WIDTH) begin
                    lane_data_d[l*BIT_DEPTH +: BIT_DEPTH] =
                        row_buf_d[(32'(beat_idx) * LANES + l) * BIT_DEPTH +: BIT_DEPTH];
                    lane_keep_d[l] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_buf_q   <= '0;
            lane_data_q <= '0;
            lane_keep_q <= '0;
        end else begin
            row_buf_q   <= row_buf_d;
            lane_data_q <= lane_data_d;
            lane_keep_q <= lane_keep_d;
        end
    end

endmodule

// File: rtl/pixel_array_readout_sequencer.sv
// Frame readout engine: one-hot row walk, settle, row latch, beat streaming with backpressure.
// Optional PIXEL_ARRAY_GRAY_DECODE_EN enables Gray decode inside the beat mux.
module pixel_array_readout_sequencer
    import pixel_array_pkg::*;
#(
    parameter int unsigned WIDTH                  = 4,
    parameter int unsigned HEIGHT                 = 4,
    parameter int unsigned BIT_DEPTH              = 8,
    parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int unsigned SETTLE_CYCLES          = 2
) (
    input  logic                       SYSTEM_CLK,
    input  logic                       READ_RESET,
    input  logic                       START,
    input  logic [WIDTH*BIT_DEPTH-1:0] ROW_DATA,
    output logic [HEIGHT-1:0]          ROW_SELECT,
    output logic                       BUSY,
    output logic                       FRAME_DONE,
    pixel_array_readout_sequencer_if.master out_if
);

    localparam int unsigned BEATS    = ceil_div(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);
    localparam int unsigned ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [ROW_W-1:0]    ROW_LAST    = ROW_W'(HEIGHT - 1);
    localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(BEATS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [HEIGHT-1:0]   ROW0_SEL    = HEIGHT'(1);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [HEIGHT-1:0]     row_select_q, row_select_d;
    logic                  valid_q, valid_d;
    logic                  sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                  frame_done_q, frame_done_d;
    logic                  capture_en, load_en, xfer;

    assign xfer = valid_q & out_if.OUT_READY;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        beat_d       = beat_q;
        settle_d     = settle_q;
        row_select_d = row_select_q;
        valid_d      = valid_q;
        sof_d        = sof_q;
        eol_d        = eol_q;
        eof_d        = eof_q;
        frame_done_d = 1'b0;
        capture_en   = 1'b0;
        load_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d      = SELECT;
                    row_d        = '0;
                    beat_d       = '0;
                    settle_d     = '0;
                    row_select_d = ROW0_SEL;
                end
            end
            SELECT: begin
                settle_d = settle_q + SETTLE_W'(1);
                if (settle_q == SETTLE_LAST) begin
                    settle_d     = '0;
                    row_select_d = '0;
                    capture_en   = 1'b1;
                    load_en      = 1'b1;
                    beat_d       = '0;
                    valid_d      = 1'b1;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (beat_q != BEAT_LAST) begin
                        beat_d  = beat_q + BEAT_W'(1);
                        load_en = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        beat_d  = '0;
                        if (row_q != ROW_LAST) begin
                            row_d        = row_q + ROW_W'(1);
                            settle_d     = '0;
                            row_select_d = ROW0_SEL << row_d;
                            state_d      = SELECT;
                        end else begin
                            row_d        = '0;
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Markers follow the beat being loaded and clear whenever the stream goes idle.
        if (load_en) begin
            sof_d = (row_d == '0) && (beat_d == '0);
            eol_d = (beat_d == BEAT_LAST);
            eof_d = (beat_d == BEAT_LAST) && (row_d == ROW_LAST);
        end else if (!valid_d) begin
            sof_d = 1'b0;
            eol_d = 1'b0;
            eof_d = 1'b0;
        end
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (READ_RESET) begin
            state_q      <= IDLE;
            row_q        <= '0;
            beat_q       <= '0;
            settle_q     <= '0;
            row_select_q <= '0;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            beat_q       <= beat_d;
            settle_q     <= settle_d;
            row_select_q <= row_select_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    pixel_array_beat_mux #(
        .WIDTH     (WIDTH),
        .BIT_DEPTH (BIT_DEPTH),
        .LANES     (OUTPUT_BUS_PIXEL_WIDTH),
        .BEAT_W    (BEAT_W)
    ) u_beat_mux (
        .clk         (SYSTEM_CLK),
        .rst         (READ_RESET),
        .capture_en  (capture_en),
        .load_en     (load_en),
        .beat_idx    (beat_d),
        .row_data    (ROW_DATA),
        .lane_data_q (out_if.OUT_DATA),
        .lane_keep_q (out_if.OUT_KEEP)
    );

    assign ROW_SELECT     = row_select_q;
    assign BUSY           = (state_q != IDLE);
    assign FRAME_DONE     = frame_done_q;
    assign out_if.OUT_VALID = valid_q;
    assign out_if.OUT_SOF   = sof_q;
    assign out_if.OUT_EOL   = eol_q;
    assign out_if.OUT_EOF   = eof_q;

endmodule

// File: tb/tb_pixel_array_readout_sequencer.sv
// Scoreboard bench for pixel_array_readout_sequencer: a 4x4/2-lane instance and a 5x3/2-lane instance.
module tb_pixel_array_readout_sequencer;

    localparam int unsigned BD = 8;
    localparam int unsigned W1 = 4, H1 = 4, L1 = 2;
    localparam int unsigned W2 = 5, H2 = 3, L2 = 2;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        sof, eol, eof;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start1, start2;
    logic [W1*BD-1:0]  rd1;
    logic [W2*BD-1:0]  rd2;
    logic [H1-1:0]     rs1;
    logic [H2-1:0]     rs2;
    logic              busy1, done1, busy2, done2;
    logic [7:0]        base1, base2;
    logic [63:0]       noise;

    pixel_array_readout_sequencer_if #(.LANES(L1), .BIT_DEPTH(BD)) if1 ();
    pixel_array_readout_sequencer_if #(.LANES(L2), .BIT_DEPTH(BD)) if2 ();

    pixel_array_readout_sequencer #(
        .WIDTH(W1), .HEIGHT(H1), .BIT_DEPTH(BD), .OUTPUT_BUS_PIXEL_WIDTH(L1), .SETTLE_CYCLES(2)
    ) dut1 (
        .SYSTEM_CLK(clk), .READ_RESET(rst), .START(start1), .ROW_DATA(rd1),
        .ROW_SELECT(rs1), .BUSY(busy1), .FRAME_DONE(done1), .out_if(if1)
    );

    pixel_array_readout_sequencer #(
        .WIDTH(W2), .HEIGHT(H2), .BIT_DEPTH(BD), .OUTPUT_BUS_PIXEL_WIDTH(L2), .SETTLE_CYCLES(2)
    ) dut2 (
        .SYSTEM_CLK(clk), .READ_RESET(rst), .START(start2), .ROW_DATA(rd2),
        .ROW_SELECT(rs2), .BUSY(busy2), .FRAME_DONE(done2), .out_if(if2)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [7:0] gray_model(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int i);
        return 8'(32'(base) + 32'(i) + 32'(r) * 32);
    endfunction

    function automatic logic [7:0] exp_pix(input logic [7:0] base, input int r, input int i);
`ifdef PIXEL_ARRAY_GRAY_DECODE_EN
        return gray_model(pix(base, r, i));
`else
        return pix(base, r, i);
`endif
    endfunction

    beat_t q1[$];
    beat_t q2[$];

    task automatic push_frame(input int dut, input logic [7:0] base);
        int w, h, l, nb;
        beat_t e;
        w  = (dut == 1) ? int'(W1) : int'(W2);
        h  = (dut == 1) ? int'(H1) : int'(H2);
        l  = (dut == 1) ? int'(L1) : int'(L2);
        nb = (w + l - 1) / l;
        for (int r = 0; r < h; r++) begin
            for (int b = 0; b < nb; b++) begin
                e.data = '0;
                e.keep = '0;
                for (int k = 0; k < l; k++) begin
                    if (b * l + k < w) begin
                        e.data[k*8 +: 8] = exp_pix(base, r, b * l + k);
                        e.keep[k]        = 1'b1;
                    end
                end
                e.sof = (r == 0) && (b == 0);
                e.eol = (b == nb - 1);
                e.eof = (b == nb - 1) && (r == h - 1);
                if (dut == 1) q1.push_back(e);
                else          q2.push_back(e);
            end
        end
    endtask

    // Pixel array model: selected row drives its pixels, otherwise the bus carries noise.
    always @(negedge clk) noise = {$urandom, $urandom};

    always_comb begin
        rd1 = noise[W1*BD-1:0];
        for (int r = 0; r < int'(H1); r++)
            if (rs1[r]) for (int i = 0; i < int'(W1); i++) rd1[i*BD +: BD] = pix(base1, r, i);
    end

    always_comb begin
        rd2 = noise[W2*BD-1:0];
        for (int r = 0; r < int'(H2); r++)
            if (rs2[r]) for (int i = 0; i < int'(W2); i++) rd2[i*BD +: BD] = pix(base2, r, i);
    end

    bit          sb1_en = 0, sb2_en = 0;
    bit          pend1 = 0, pend2 = 0, stall1_prev = 0, stall2_prev = 0;
    bit          stall_en = 0;
    int          stall_left = 0;
    int          xfer1 = 0;
    logic [3:0]  rs_log[$];

    // Monitor 1: decides READY for the coming edge, then scores what the DUT presents.
    always @(negedge clk) begin
        beat_t e;
        bit    exp_done;
        if (sb1_en) begin
            if (if1.OUT_VALID && stall_en && xfer1 == 5 && stall_left > 0) begin
                if1.OUT_READY = 1'b0;
                stall_left--;
            end else begin
                if1.OUT_READY = 1'b1;
            end
            exp_done = pend1;
            pend1    = 0;
            check_eq("frame_done1", 64'(done1), 64'(exp_done));
            if (stall1_prev) check_eq("valid_held1", 64'(if1.OUT_VALID), 64'd1);
            if (rs1 != '0) rs_log.push_back(rs1);
            if (if1.OUT_VALID) begin
                check_eq("select_off_in_stream1", 64'(rs1), 64'd0);
                if (q1.size() == 0) begin
                    check_eq("extra_beat1", 64'(if1.OUT_VALID), 64'd0);
                end else begin
                    e = q1[0];
                    check_eq("data1", 64'(if1.OUT_DATA), e.data);
                    check_eq("keep1", 64'(if1.OUT_KEEP), 64'(e.keep));
                    check_eq("sof1",  64'(if1.OUT_SOF),  64'(e.sof));
                    check_eq("eol1",  64'(if1.OUT_EOL),  64'(e.eol));
                    check_eq("eof1",  64'(if1.OUT_EOF),  64'(e.eof));
                    if (if1.OUT_READY) begin
                        void'(q1.pop_front());
                        xfer1++;
                        if (e.eof) pend1 = 1;
                    end
                end
            end
            stall1_prev = if1.OUT_VALID && !if1.OUT_READY;
        end else begin
            if1.OUT_READY = 1'b1;
        end
    end

    // Monitor 2: random backpressure.
    always @(negedge clk) begin
        beat_t e;
        bit    exp_done;
        if (sb2_en) begin
            if2.OUT_READY = ($urandom_range(0, 3) != 0);
            exp_done = pend2;
            pend2    = 0;
            check_eq("frame_done2", 64'(done2), 64'(exp_done));
            if (stall2_prev) check_eq("valid_held2", 64'(if2.OUT_VALID), 64'd1);
            if (if2.OUT_VALID) begin
                if (q2.size() == 0) begin
                    check_eq("extra_beat2", 64'(if2.OUT_VALID), 64'd0);
                end else begin
                    e = q2[0];
                    check_eq("data2", 64'(if2.OUT_DATA), e.data);
                    check_eq("keep2", 64'(if2.OUT_KEEP), 64'(e.keep));
                    check_eq("sof2",  64'(if2.OUT_SOF),  64'(e.sof));
                    check_eq("eol2",  64'(if2.OUT_EOL),  64'(e.eol));
                    check_eq("eof2",  64'(if2.OUT_EOF),  64'(e.eof));
                    if (if2.OUT_READY) begin
                        void'(q2.pop_front());
                        if (e.eof) pend2 = 1;
                    end
                end
            end
            stall2_prev = if2.OUT_VALID && !if2.OUT_READY;
        end else begin
            if2.OUT_READY = 1'b1;
        end
    end

    task automatic pulse_start1();
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic wait_done(input int dut, input int budget);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = (dut == 1) ? done1 : done2;
        end
        if (!seen) check_eq("frame_timeout", 64'(seen), 64'd1);
    endtask

    task automatic check_idle1(input string tag);
        check_eq({tag, "_rs"},   64'(rs1),           64'd0);
        check_eq({tag, "_busy"}, 64'(busy1),         64'd0);
        check_eq({tag, "_done"}, 64'(done1),         64'd0);
        check_eq({tag, "_vld"},  64'(if1.OUT_VALID), 64'd0);
        check_eq({tag, "_data"}, 64'(if1.OUT_DATA),  64'd0);
        check_eq({tag, "_keep"}, 64'(if1.OUT_KEEP),  64'd0);
        check_eq({tag, "_flag"}, 64'({if1.OUT_SOF, if1.OUT_EOL, if1.OUT_EOF}), 64'd0);
    endtask

    initial begin
        int lat;
        bit hit;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        base1 = 8'h10; base2 = 8'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle1("reset1");
        check_eq("reset2_rs",   64'(rs2),   64'd0);
        check_eq("reset2_busy", 64'(busy2), 64'd0);
        check_eq("reset2_vld",  64'(if2.OUT_VALID), 64'd0);
        check_eq("reset2_keep", 64'(if2.OUT_KEEP),  64'd0);
        rst = 1'b0;
        sb1_en = 1; sb2_en = 1;
        @(negedge clk);

        // Frame A: nominal, latency and row-select walk
        rs_log.delete();
        push_frame(1, base1);
        pulse_start1();
        lat = 0;
        hit = 0;
        while (!hit && lat < 50) begin
            @(negedge clk);
            lat++;
            hit = if1.OUT_VALID;
        end
        check_eq("first_valid_latency", 64'(lat), 64'd3);
        check_eq("busy_in_frame", 64'(busy1), 64'd1);
        wait_done(1, 200);
        check_eq("frameA_drained", 64'(q1.size()), 64'd0);
        check_eq("rs_log_len", 64'(rs_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < rs_log.size(); k++)
            check_eq("rs_walk", 64'(rs_log[k]), 64'(4'b0001 << (k / 2)));

        // Frame B: three-cycle stall on beat 1 of row 2
        @(negedge clk);
        base1 = 8'h40;
        xfer1 = 0; stall_left = 3; stall_en = 1;
        push_frame(1, base1);
        pulse_start1();
        wait_done(1, 200);
        stall_en = 0;
        check_eq("stall_applied", 64'(stall_left), 64'd0);
        check_eq("frameB_drained", 64'(q1.size()), 64'd0);

        // Frame C: START held through the frame gives exactly one frame
        @(negedge clk);
        base1 = 8'h20;
        push_frame(1, base1);
        start1 = 1'b1;
        wait_done(1, 200);
        start1 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check_eq("no_second_frame", 64'(busy1), 64'd0);
        end
        check_eq("frameC_drained", 64'(q1.size()), 64'd0);

        // Frame D: pixel 0 of row 0 is 8'hC0 (decoded to 8'h80 when Gray decode is built in)
        base1 = 8'hC0;
        push_frame(1, base1);
        pulse_start1();
        wait_done(1, 200);
        check_eq("frameD_drained", 64'(q1.size()), 64'd0);

        // Reset during SELECT of row 1, then during STREAM
        @(negedge clk);
        sb1_en = 0;
        base1 = 8'h10;
        pulse_start1();
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = (rs1 == 4'b0010);
        end
        check_eq("reach_row1_select", 64'(hit), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle1("rst_select");
        rst = 1'b0;
        @(negedge clk);
        pulse_start1();
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = if1.OUT_VALID;
        end
        check_eq("reach_stream", 64'(hit), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle1("rst_stream");
        rst = 1'b0;
        q1.delete();
        pend1 = 0; stall1_prev = 0;
        sb1_en = 1;
        @(negedge clk);
        push_frame(1, base1);
        pulse_start1();
        wait_done(1, 200);
        check_eq("restart_drained", 64'(q1.size()), 64'd0);

        // Second instance: WIDTH=5 gives a partial third beat per row
        @(negedge clk);
        base2 = 8'h30;
        push_frame(2, base2);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        wait_done(2, 400);
        check_eq("dut2_drained", 64'(q2.size()), 64'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
